game_state_ctrl: RTL and testbench

//  Top-level game sequencer. Tracks lives and runs IDLE/PLAY/CAUGHT/OVER.

---
 rtl/game_state_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game sequencer: lives tracking and IDLE/PLAY/CAUGHT/OVER flow, with every state change aligned to the vblnk rise.
// Optional overlay blink in OVER is built when GAMEOVER_BLINK_EN is defined.
module game_state_ctrl #(
  parameter int LIVES            = 3,
  parameter int CAUGHT_FRAMES    = 60,
  parameter int OVER_HOLD_FRAMES = 120,
  parameter int BLINK_FRAMES     = 30
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vblnk,
  input  logic                         start,
  input  logic                         caught,
  output logic                         over,
  output logic                         play,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic [1:0]                   state_dbg
);

  localparam int LW    = $clog2(LIVES + 1);
  localparam int MAX_A = (CAUGHT_FRAMES > OVER_HOLD_FRAMES) ? CAUGHT_FRAMES : OVER_HOLD_FRAMES;
  localparam int MAX_F = (MAX_A > BLINK_FRAMES) ? MAX_A : BLINK_FRAMES;
  localparam int CW    = $clog2(MAX_F + 1);

  localparam logic [CW-1:0] CAUGHT_LAST = CW'(CAUGHT_FRAMES - 1);
  localparam logic [CW-1:0] OVER_HOLD   = CW'(OVER_HOLD_FRAMES);
  localparam logic [LW-1:0] LIVES_INIT  = LW'(LIVES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_CAUGHT = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            vblnk_q;
  logic            start_q;
  logic            start_req_q, start_req_d;
  logic            caught_req_q, caught_req_d;
  logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic            play_q, play_d;
  logic            over_q, over_d;

  logic            frame_tick;
  logic            start_pend;
  logic            caught_pend;
  logic            over_hold_done;

  // A start edge or catch in the tick cycle itself counts for that tick.
  assign frame_tick     = vblnk & ~vblnk_q;
  assign start_pend     = start_req_q | (start & ~start_q);
  assign caught_pend    = caught_req_q | ((state_q == S_PLAY) & caught);
  assign over_hold_done = (frame_cnt_q == OVER_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vblnk_q      <= 1'b0;
      start_q      <= 1'b0;
      start_req_q  <= 1'b0;
      caught_req_q <= 1'b0;
      frame_cnt_q  <= '0;
      lives_q      <= LIVES_INIT;
      play_q       <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vblnk_q      <= vblnk;
      start_q      <= start;
      start_req_q  <= start_req_d;
      caught_req_q <= caught_req_d;
      frame_cnt_q  <= frame_cnt_d;
      lives_q      <= lives_d;
      play_q       <= play_d;
      over_q       <= over_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    lives_d      = lives_q;
    start_req_d  = start_pend;
    caught_req_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        lives_d = LIVES_INIT;
        if (frame_tick && start_pend) begin
          state_d     = S_PLAY;
          start_req_d = 1'b0;
        end
      end
      S_PLAY: begin
        start_req_d  = 1'b0;
        caught_req_d = caught_pend;
        if (frame_tick && caught_pend) begin
          caught_req_d = 1'b0;
          frame_cnt_d  = '0;
          if (lives_q > LW'(1)) begin
            lives_d = lives_q - LW'(1);
            state_d = S_CAUGHT;
          end else begin
            lives_d = '0;
            state_d = S_OVER;
          end
        end
      end
      S_CAUGHT: begin
        start_req_d = 1'b0;
        if (frame_tick) begin
          if (frame_cnt_q == CAUGHT_LAST) begin
            state_d     = S_PLAY;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
      end
      S_OVER: begin
        if (!over_hold_done) start_req_d = 1'b0;
        if (frame_tick) begin
          if (over_hold_done && start_pend) begin
            state_d     = S_PLAY;
            lives_d     = LIVES_INIT;
            start_req_d = 1'b0;
            frame_cnt_d = '0;
          end else if (!over_hold_done) begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef GAMEOVER_BLINK_EN
  // blink_off_q is the dark half of the blink; both regs sit at 0 outside OVER.
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;

  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (state_d != S_OVER) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if ((state_q == S_OVER) && frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    play_d = (state_d == S_PLAY);
    over_d = (state_d == S_OVER) & ~blink_off_d;
  end
`else
  always_comb begin
    play_d = (state_d == S_PLAY);
    over_d = (state_d == S_OVER);
  end
`endif

  assign over      = over_q;
  assign play      = play_q;
  assign lives     = lives_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: a table of frame-level vectors plus hand sequences
// for output latency, same-cycle start/tick, mid-frame reset and (GAMEOVER_BLINK_EN) blink.
module tb_game_state_ctrl;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_CAUGHT = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

`ifdef GAMEOVER_BLINK_EN
  localparam logic OVER_MID = 1'b0;
`else
  localparam logic OVER_MID = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       vblnk;
  logic       start;
  logic       caught;
  logic       over;
  logic       play;
  logic [1:0] lives;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       p_start;
    logic       p_caught;
    int         frames;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  game_state_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .vblnk     (vblnk),
    .start     (start),
    .caught    (caught),
    .over      (over),
    .play      (play),
    .lives     (lives),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] pk(input logic [1:0] st, input logic pl, input logic ov,
                                    input logic [1:0] lv);
    return {st, pl, ov, lv};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {state_dbg, play, over, lives};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual{st,play,over,lives}=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // One frame: 5 cycles low (optional pulses in the 3rd), then 3 cycles of vblnk high.
  task automatic run_frame(input logic p_start, input logic p_caught);
    vblnk = 1'b0;
    step();
    step();
    start  = p_start;
    caught = p_caught;
    step();
    start  = 1'b0;
    caught = 1'b0;
    step();
    step();
    vblnk = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic frames(input int n);
    repeat (n) run_frame(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    vblnk = 1'b0;
    rst   = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic add(input string name, input logic s, input logic c, input int n,
                     input logic [5:0] exp);
    vec_t v;
    v.name = name; v.p_start = s; v.p_caught = c; v.frames = n; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; vblnk = 1'b0; start = 1'b0; caught = 1'b0;

    add("idle_no_start",      0, 0,  2, pk(ST_IDLE,   0, 0, 2'd3));
    add("start_to_play",      1, 0,  1, pk(ST_PLAY,   1, 0, 2'd3));
    add("play_steady",        0, 0,  3, pk(ST_PLAY,   1, 0, 2'd3));
    add("catch1",             0, 1,  1, pk(ST_CAUGHT, 0, 0, 2'd2));
    add("caught_in_caught",   0, 1,  1, pk(ST_CAUGHT, 0, 0, 2'd2));
    add("caught_tick59",      0, 0, 58, pk(ST_CAUGHT, 0, 0, 2'd2));
    add("caught_tick60",      0, 0,  1, pk(ST_PLAY,   1, 0, 2'd2));
    add("catch2",             0, 1,  1, pk(ST_CAUGHT, 0, 0, 2'd1));
    add("caught2_done",       0, 0, 60, pk(ST_PLAY,   1, 0, 2'd1));
    add("catch3_over",        0, 1,  1, pk(ST_OVER,   0, 1, 2'd0));
    add("over_hold49",        0, 0, 49, pk(ST_OVER,   0, OVER_MID, 2'd0));
    add("over_start_at50",    1, 0,  1, pk(ST_OVER,   0, OVER_MID, 2'd0));
    add("over_hold120",       0, 0, 70, pk(ST_OVER,   0, 1, 2'd0));
    add("over_no_stale_req",  0, 0,  1, pk(ST_OVER,   0, 1, 2'd0));
    add("over_restart",       1, 0,  1, pk(ST_PLAY,   1, 0, 2'd3));
    add("caught_and_start",   1, 1,  1, pk(ST_CAUGHT, 0, 0, 2'd2));
    add("after_simul_return", 0, 0, 60, pk(ST_PLAY,   1, 0, 2'd2));
    add("after_simul_steady", 0, 0,  2, pk(ST_PLAY,   1, 0, 2'd2));

    do_reset();
    check("reset_state", pk(ST_IDLE, 0, 0, 2'd3));

    // Start pulse mid-frame: play must wait for the vblnk rise, then follow 1 clk later.
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("latency_wait", pk(ST_IDLE, 0, 0, 2'd3));
    end
    vblnk = 1'b1;
    check_bit("latency_pre_edge_play", play, 1'b0);
    step();
    check("latency_after_tick", pk(ST_PLAY, 1, 0, 2'd3));
    step();
    step();
    frames(1);
    check("latency_hold_play", pk(ST_PLAY, 1, 0, 2'd3));

    // Start edge in the tick cycle itself counts for that tick.
    do_reset();
    check("reset_again", pk(ST_IDLE, 0, 0, 2'd3));
    step();
    step();
    vblnk = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_same_as_tick", pk(ST_PLAY, 1, 0, 2'd3));
    step();
    step();

    do_reset();
    foreach (vecs[i]) begin
      run_frame(vecs[i].p_start, vecs[i].p_caught);
      if (vecs[i].frames > 1) frames(vecs[i].frames - 1);
      check(vecs[i].name, vecs[i].exp);
    end

    // Mid-frame reset in CAUGHT with a start request pending.
    run_frame(1'b0, 1'b1);
    check("pre_rst_caught", pk(ST_CAUGHT, 0, 0, 2'd1));
    vblnk = 1'b0;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    rst   = 1'b1;
    step();
    rst = 1'b0;
    check("rst_in_caught", pk(ST_IDLE, 0, 0, 2'd3));
    frames(2);
    check("rst_caught_needs_start", pk(ST_IDLE, 0, 0, 2'd3));
    run_frame(1'b1, 1'b0);
    check("replay_after_rst", pk(ST_PLAY, 1, 0, 2'd3));

    // Lose all lives, then reset mid-frame in OVER.
    run_frame(1'b0, 1'b1);
    frames(60);
    run_frame(1'b0, 1'b1);
    frames(60);
    run_frame(1'b0, 1'b1);
    check("over_entry", pk(ST_OVER, 0, 1, 2'd0));
    frames(10);
    vblnk = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_in_over", pk(ST_IDLE, 0, 0, 2'd3));
    frames(1);
    check("rst_over_stays_idle", pk(ST_IDLE, 0, 0, 2'd3));

`ifdef GAMEOVER_BLINK_EN
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b1);
    frames(60);
    run_frame(1'b0, 1'b1);
    frames(60);
    run_frame(1'b0, 1'b1);
    check("blink_entry", pk(ST_OVER, 0, 1, 2'd0));
    for (int k = 1; k <= 125; k++) begin
      run_frame(1'b0, 1'b0);
      check_bit("blink_phase", over, ((k / 30) % 2) == 0);
    end
    run_frame(1'b1, 1'b0);
    check("blink_restart", pk(ST_PLAY, 1, 0, 2'd3));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
